// File: rtl/l2_dr_req_arb.sv
// l2_dr_req_arb: round-robin share of the L2->directory request channel between
// the L2 and the L2TLB, plus nid-parity steering of returning directory snacks.
module l2_dr_req_arb #(
    parameter int unsigned REQ_W   = 64,
    parameter int unsigned SNACK_W = 96,
    parameter int unsigned NID_BIT = 0
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               l2_req_valid,
    output logic               l2_req_retry,
    input  logic [REQ_W-1:0]   l2_req,

    input  logic               tlb_req_valid,
    output logic               tlb_req_retry,
    input  logic [REQ_W-1:0]   tlb_req,

    output logic               l2todr_req_valid,
    input  logic               l2todr_req_retry,
    output logic [REQ_W-1:0]   l2todr_req,

    input  logic               drtol2_snack_valid,
    output logic               drtol2_snack_retry,
    input  logic [SNACK_W-1:0] drtol2_snack,

    output logic               l2_snack_valid,
    input  logic               l2_snack_retry,
    output logic               tlb_snack_valid,
    input  logic               tlb_snack_retry,
    output logic [SNACK_W-1:0] snack_out
);

    typedef enum logic {
        SIDE_L2  = 1'b0,
        SIDE_TLB = 1'b1
    } side_e;

    logic               req_q_valid;
    logic [REQ_W-1:0]   req_q;
    side_e              rr_last;

    logic               snk_q_valid;
    logic [SNACK_W-1:0] snk_q;

    logic               free_c;
    logic               grant_l2_c;
    logic               grant_tlb_c;
    logic               snk_dest_tlb_c;
    logic               snk_free_c;

    // Request arbitration: a tie goes to the side that did not win last.
    always_comb begin
        free_c      = 1'b0;
        grant_l2_c  = 1'b0;
        grant_tlb_c = 1'b0;
        free_c      = !req_q_valid || !l2todr_req_retry;
        grant_l2_c  = free_c && l2_req_valid &&
                      (!tlb_req_valid || (rr_last == SIDE_TLB));
        grant_tlb_c = free_c && tlb_req_valid && !grant_l2_c;
    end

    // Input retries are held high while reset is asserted.
    always_comb begin
        l2_req_retry  = 1'b1;
        tlb_req_retry = 1'b1;
        if (reset) begin
            l2_req_retry  = !grant_l2_c;
            tlb_req_retry = !grant_tlb_c;
        end
    end

    // One-entry request output stage and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q_valid <= 1'b0;
            req_q       <= '0;
            rr_last     <= SIDE_TLB;
        end else if (free_c) begin
            req_q_valid <= grant_l2_c || grant_tlb_c;
            if (grant_l2_c) begin
                req_q   <= l2_req;
                rr_last <= SIDE_L2;
            end else if (grant_tlb_c) begin
                req_q   <= tlb_req;
                rr_last <= SIDE_TLB;
            end
        end
    end

    assign l2todr_req_valid = req_q_valid;
    assign l2todr_req       = req_q;

    // Snack destination is nid parity; only the selected destination can stall it.
    always_comb begin
        snk_dest_tlb_c = 1'b0;
        snk_free_c     = 1'b0;
        snk_dest_tlb_c = snk_q[NID_BIT];
        snk_free_c     = !snk_q_valid ||
                         !(snk_dest_tlb_c ? tlb_snack_retry : l2_snack_retry);
    end

    assign drtol2_snack_retry = !reset || !snk_free_c;

    // Single snack register; head-of-line blocking across destinations is intended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snk_q_valid <= 1'b0;
            snk_q       <= '0;
        end else if (snk_free_c) begin
            snk_q_valid <= drtol2_snack_valid;
            if (drtol2_snack_valid) begin
                snk_q <= drtol2_snack;
            end
        end
    end

    assign l2_snack_valid  = snk_q_valid && !snk_dest_tlb_c;
    assign tlb_snack_valid = snk_q_valid && snk_dest_tlb_c;
    assign snack_out       = snk_q;

endmodule
